// File: rtl/oka_red_if.sv
// Stream bundle for the GF(2^16) product reducer: input product side and output remainder side.
interface oka_red_if;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_res
  );

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_res
  );
endinterface

// File: rtl/oka_red_pipe_16.sv
// Two-stage GF(2) reducer of a 31-bit OKA product modulo x^16 + POLY, with valid/ready flow control.
// Optional XOR accumulator of delivered results is enabled by defining OKA_RED_ACC_EN.
module oka_red_pipe_16 #(
  parameter logic [15:0] POLY = 16'h002D
) (
  input  logic        clk,
  input  logic        rst,
`ifdef OKA_RED_ACC_EN
  input  logic        acc_clr,
  output logic [15:0] acc_q,
`endif
  oka_red_if.slave    bus
);

  // x^16 is included so that each fold also clears the bit it consumes.
  localparam logic [30:0] RED_P1 = {14'd0, 1'b1, POLY};
  localparam logic [22:0] RED_P2 = {6'd0, 1'b1, POLY};

  // Descending order lets a high fold land in a lower bit that is folded later.
  function automatic logic [22:0] fold_p1(input logic [30:0] p);
    logic [30:0] v;
    v = p;
    for (int k = 30; k >= 23; k--)
      if (v[k]) v = v ^ (RED_P1 << (k - 16));
    return v[22:0];
  endfunction

  function automatic logic [15:0] fold_p2(input logic [22:0] p);
    logic [22:0] v;
    v = p;
    for (int k = 22; k >= 16; k--)
      if (v[k]) v = v ^ (RED_P2 << (k - 16));
    return v[15:0];
  endfunction

  logic        vld_p1;
  logic [22:0] data_p1;
  logic        vld_p2;
  logic [15:0] data_p2;
  logic        s1_adv;
  logic        s2_adv;

  assign s2_adv       = ~vld_p2 | bus.out_ready;
  assign s1_adv       = ~vld_p1 | s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = vld_p2;
  assign bus.out_res   = data_p2;

  // Stage boundary: input -> S1 (bits 30..23 folded) -> S2 (bits 22..16 folded)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      if (s2_adv) begin
        vld_p2  <= vld_p1;
        data_p2 <= fold_p2(data_p1);
      end
      if (s1_adv) begin
        vld_p1  <= bus.in_valid;
        data_p1 <= fold_p1(bus.in_prod);
      end
    end
  end

`ifdef OKA_RED_ACC_EN
  logic out_xfer;
  assign out_xfer = vld_p2 & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc_q <= '0;
    else if (acc_clr)
      acc_q <= out_xfer ? data_p2 : 16'h0000;
    else if (out_xfer)
      acc_q <= acc_q ^ data_p2;
  end
`endif

endmodule

// File: doc/oka_red_pipe_16.md
OKA_RED_PIPE_16 -- requirements
Module: oka_red_pipe_16

Interface
REQ-001 Parameter POLY, default 16'h002D, low 16 coefficients of the reduction polynomial P(x) = x^16 + POLY(x) over GF(2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  in_prod holds a valid product.
REQ-005 in_ready  output  1  block accepts in_prod this cycle.
REQ-006 in_prod  input  31  unreduced GF(2) product; bit i is the coefficient of x^i, from the 16-bit OKA multiplier y output.
REQ-007 out_valid  output  1  out_res holds a valid result.
REQ-008 out_ready  input  1  consumer accepts out_res this cycle.
REQ-009 out_res  output  16  in_prod mod P(x).

Function
REQ-010 Transfer occurs on a port only when valid and ready are both 1 at a rising edge.
REQ-011 Two register stages, S1 and S2, each holding a valid flag and data.
REQ-012 S1 captures in_prod with bits 30..23 folded: for each set bit k in 30..23, XOR POLY shifted left by (k-16). This leaves a 23-bit value.
REQ-013 S2 captures S1 data with bits 22..16 folded the same way. This leaves the 16-bit remainder.
REQ-014 out_res equals S2 data; out_valid equals the S2 valid flag.
REQ-015 Arithmetic is XOR only: no carries, and no integer addition anywhere.
REQ-016 Latency is exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-017 Throughput is one result per cycle with no bubbles while out_ready is 1.
REQ-018 s2_adv = ~S2.valid | out_ready.
REQ-019 s1_adv = ~S1.valid | s2_adv.
REQ-020 in_ready = s1_adv, derived combinationally; it is asserted even when in_valid is 0.
REQ-021 When s2_adv is 1, S2 loads S1 (both valid and data).
REQ-022 When s1_adv is 1, S1 loads the input, with valid = in_valid.
REQ-023 When out_ready is 0 and both stages are full, both stages hold and in_ready = 0.
REQ-024 Output data is stable while out_valid = 1 and out_ready = 0.
REQ-025 No transfer is lost or duplicated, including when an input and an output transfer occur in the same cycle on a full pipe.
REQ-026 in_prod values with bit 30 set are legal, and all 31 bits are reduced.
REQ-027 Results are delivered in strict input order.

Reset
REQ-028 While rst = 1: S1.valid = 0, S2.valid = 0, out_valid = 0, out_res = 16'h0000, and in_ready = 1.
REQ-029 Reset mid-operation discards all in-flight data with no output transfer.
REQ-030 The first acceptance is possible on the first rising edge after rst falls.

Configuration
REQ-031 Macro OKA_RED_ACC_EN, when defined, adds two ports.
- acc_clr: input, 1 bit.
- acc_q: output, 16 bits.
REQ-032 With OKA_RED_ACC_EN defined, each output transfer sets acc_q <= acc_q ^ out_res.
REQ-033 With OKA_RED_ACC_EN defined, acc_clr = 1 synchronously sets acc_q <= 0.
REQ-034 With OKA_RED_ACC_EN defined, acc_clr and an output transfer in the same cycle give acc_q <= out_res.
REQ-035 With OKA_RED_ACC_EN defined, rst clears acc_q to 16'h0000.
REQ-036 Without OKA_RED_ACC_EN, the acc_clr and acc_q ports and the accumulator register do not exist; all other behaviour is identical.

Verification
REQ-037 Single-input cases, out_ready = 1, POLY = 16'h002D:
- in_prod 31'h0000ABCD -> out_res 16'hABCD, out_valid exactly 2 cycles after acceptance.
- in_prod 31'h00010000 (x^16) -> out_res 16'h002D.
- in_prod 31'h00020000 (x^17) -> out_res 16'h005A.
- in_prod 31'h00018000 -> out_res 16'h802D.
REQ-038 Back-to-back inputs x^16, 31'h1, 31'h0000ABCD with out_ready = 1 -> outputs 002D, 0001, ABCD on consecutive cycles.
REQ-039 Stall case:
- Hold out_ready = 0 and offer 3 inputs -> 2 are accepted, then in_ready = 0 and out_res stays stable.
- Release out_ready -> all 3 results delivered in order, each exactly once.
REQ-040 Random check: 10,000 random 31-bit in_prod values with random out_ready -> each out_res equals the reference model polynomial remainder mod P(x), in order.
REQ-041 Reset mid-operation: assert rst with both stages full -> out_valid falls immediately, no stale output appears after release, and in_ready = 1.
REQ-042 With OKA_RED_ACC_EN defined:
- Results 002D then 005A -> acc_q = 0077.
- acc_clr pulsed with a transfer of ABCD -> acc_q = ABCD.
